// File: rtl/xmr_probe_channel_arbiter.sv
// Round-robin arbiter sharing one pipelined XMR probe channel among NUM_REQ
// requesters, with credit-based flow control toward the sink buffer.
module xmr_probe_channel_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned CREDITS     = 4,
  localparam int unsigned ID_W       = $clog2(NUM_REQ),
  localparam int unsigned CW         = $clog2(CREDITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [ID_W-1:0]           out_id,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      credit_return,
  output logic [CW-1:0]             credit_avail,
  output logic                      busy,
  output logic                      credit_err
);

  logic [ID_W-1:0]   rr_ptr;
  logic [CW-1:0]     credit_cnt;
  logic [CW-1:0]     credit_nxt;
  logic              err_set;
  logic              xfer;
  logic              found;
  logic [ID_W-1:0]   grant_idx;
  logic [DATA_W-1:0] grant_data;
  int unsigned       idx;
  logic              any_valid;

  logic              stg_valid [PIPE_STAGES];
  logic [ID_W-1:0]   stg_id    [PIPE_STAGES];
  logic [DATA_W-1:0] stg_data  [PIPE_STAGES];

  // Grant search starts at rr_ptr and wraps; blocked entirely with no credits.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (credit_cnt != '0) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(rr_ptr) + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin
          found          = 1'b1;
          req_ready[idx] = 1'b1;
          grant_idx      = ID_W'(idx);
        end
      end
    end
  end

  assign xfer       = found;
  assign grant_data = req_data[32'(grant_idx)*DATA_W +: DATA_W];

  // Credit bookkeeping; a return with a full pool is flagged, never counted.
  always_comb begin
    credit_nxt = credit_cnt;
    err_set    = 1'b0;
    case ({xfer, credit_return})
      2'b10: credit_nxt = credit_cnt - CW'(1);
      2'b01: begin
        if (credit_cnt == CW'(CREDITS)) err_set = 1'b1;
        else                            credit_nxt = credit_cnt + CW'(1);
      end
      default: credit_nxt = credit_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      credit_cnt <= CW'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      if (xfer) rr_ptr <= ID_W'((32'(grant_idx) + 1) % NUM_REQ);
      credit_cnt <= credit_nxt;
      if (err_set) credit_err <= 1'b1;
    end
  end

  // Stall-free delivery pipe; stage 0 is zeroed on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(PIPE_STAGES); s++) begin
        stg_valid[s] <= 1'b0;
        stg_id[s]    <= '0;
        stg_data[s]  <= '0;
      end
    end else begin
      stg_valid[0] <= xfer;
      stg_id[0]    <= xfer ? grant_idx : '0;
      stg_data[0]  <= xfer ? grant_data : '0;
      for (int s = 1; s < int'(PIPE_STAGES); s++) begin
        stg_valid[s] <= stg_valid[s-1];
        stg_id[s]    <= stg_id[s-1];
        stg_data[s]  <= stg_data[s-1];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int s = 0; s < int'(PIPE_STAGES); s++) any_valid = any_valid | stg_valid[s];
  end

  assign out_valid    = stg_valid[PIPE_STAGES-1];
  assign out_id       = stg_id[PIPE_STAGES-1];
  assign out_data     = stg_data[PIPE_STAGES-1];
  assign credit_avail = credit_cnt;
  assign busy         = any_valid | (credit_cnt != CW'(CREDITS));

endmodule

// File: tb/tb_xmr_probe_channel_arbiter.sv
// Directed bench for xmr_probe_channel_arbiter (NUM_REQ=4, DATA_W=8,
// PIPE_STAGES=2, CREDITS=4); expected values are hand-derived.
module tb_xmr_probe_channel_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CW      = 3;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [ID_W-1:0]           out_id;
  logic [DATA_W-1:0]         out_data;
  logic                      credit_return;
  logic [CW-1:0]             credit_avail;
  logic                      busy;
  logic                      credit_err;

  int n_tests = 0;
  int n_fail  = 0;

  xmr_probe_channel_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .PIPE_STAGES(2), .CREDITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
    .credit_return(credit_return), .credit_avail(credit_avail),
    .busy(busy), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    credit_return = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin : stim
    logic [1:0] g [4];
    g[0] = 2'd0; g[1] = 2'd2; g[2] = 2'd0; g[3] = 2'd2;
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    credit_return = 1'b0;
    do_reset();

    // Idle after reset
    for (int i = 0; i < 10; i++) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_id", 32'(out_id), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_credit", 32'(credit_avail), 4);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_err", 32'(credit_err), 0);

    // Single beat from requester 0, latency 2
    req_valid = 4'b0001;
    req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
    #1 check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("single_credit", 32'(credit_avail), 3);
    check("single_out_early", 32'(out_valid), 0);
    check("single_busy", 32'(busy), 1);
    tick();
    check("single_out_valid", 32'(out_valid), 1);
    check("single_out_id", 32'(out_id), 0);
    check("single_out_data", 32'(out_data), 32'hA5);
    tick();
    check("single_out_gone", 32'(out_valid), 0);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("single_credit_back", 32'(credit_avail), 4);
    check("single_idle_busy", 32'(busy), 0);

    // Full round robin with credit returns from the first output onward
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4) ? 4'hF : 4'h0;
      credit_return = (k >= 2);
      #1;
      if (k < 4) check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1) << k);
      tick();
      if (k >= 1 && k <= 4) begin
        check($sformatf("rr_out_valid_%0d", k), 32'(out_valid), 1);
        check($sformatf("rr_out_id_%0d", k), 32'(out_id), 32'(k - 1));
        check($sformatf("rr_out_data_%0d", k), 32'(out_data), 32'h10 + 32'(k - 1));
      end
    end
    credit_return = 1'b0;
    check("rr_credit_end", 32'(credit_avail), 4);

    // Sparse requesters drain credits, then one credit allows one more grant
    req_data = {8'h23, 8'h22, 8'h21, 8'h20};
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("sp_ready_%0d", k), 32'(req_ready), 32'(1) << g[k]);
      tick();
      if (k >= 1) check($sformatf("sp_out_id_%0d", k), 32'(out_id), 32'(g[k-1]));
    end
    check("sp_blocked_ready", 32'(req_ready), 0);
    check("sp_blocked_credit", 32'(credit_avail), 0);
    credit_return = 1'b1;
    #1 check("sp_blocked_ready2", 32'(req_ready), 0);
    tick();
    credit_return = 1'b0;
    check("sp_last_out_id", 32'(out_id), 2);
    check("sp_credit_one", 32'(credit_avail), 1);
    #1 check("sp_regrant", 32'(req_ready), 32'h1);
    tick();
    check("sp_reblocked_ready", 32'(req_ready), 0);
    check("sp_reblocked_credit", 32'(credit_avail), 0);
    req_valid = '0;
    tick();
    check("sp_regrant_out_valid", 32'(out_valid), 1);
    check("sp_regrant_out_data", 32'(out_data), 32'h20);

    // Simultaneous transfer and return, then overflow of the credit pool
    credit_return = 1'b1;
    tick();
    tick();
    credit_return = 1'b0;
    check("sim_credit_pre", 32'(credit_avail), 2);
    req_valid = 4'b0001;
    credit_return = 1'b1;
    #1 check("sim_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    credit_return = 1'b0;
    check("sim_credit_hold", 32'(credit_avail), 2);
    credit_return = 1'b1;
    tick();
    tick();
    check("ovf_credit_full", 32'(credit_avail), 4);
    check("ovf_err_clear", 32'(credit_err), 0);
    tick();
    credit_return = 1'b0;
    check("ovf_credit_sat", 32'(credit_avail), 4);
    check("ovf_err_set", 32'(credit_err), 1);
    for (int i = 0; i < 3; i++) tick();
    check("ovf_err_sticky", 32'(credit_err), 1);
    check("ovf_busy", 32'(busy), 0);

    // Async reset with a beat on the output discards it
    req_valid = 4'b0010;
    #1 check("rst_mid_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    check("rst_mid_out_before", 32'(out_valid), 1);
    check("rst_mid_out_data_before", 32'(out_data), 32'h21);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_out_data", 32'(out_data), 0);
    check("rst_mid_credit", 32'(credit_avail), 4);
    check("rst_mid_err", 32'(credit_err), 0);
    check("rst_mid_busy", 32'(busy), 0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_post_out_%0d", i), 32'(out_valid), 0);
    end
    check("rst_post_credit", 32'(credit_avail), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
